// File: rtl/uart_rx_link.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_link
// Purpose  : 8N1 UART receiver with a 16x oversampled, majority-voted decoder
//            and a one-entry valid/ready holding register.
// Revision : 1.0
// ============================================================================
module uart_rx_link #(
    parameter int CLK_HZ     = 75_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = (CLK_HZ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int c_DIV_W = $clog2(DIV + 1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_START     = 3'd1;
    localparam logic [2:0] c_S_DATA      = 3'd2;
    localparam logic [2:0] c_S_STOP      = 3'd3;
    localparam logic [2:0] c_S_WAIT_IDLE = 3'd4;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [3:0]         r_tick_idx;
    logic [2:0]         r_bit_idx;
    logic               r_s7;
    logic               r_s8;
    logic [7:0]         r_shift;
    logic [7:0]         r_byte;
    logic               r_dlv;
    logic               r_ferr_p;
    logic               w_tick;
    logic               w_t9;
    logic               w_t16;
    logic               w_vote;
    logic               w_deliver;
    logic               w_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick = (r_div_cnt == c_DIV_W'(DIV - 1));
    assign w_t9   = w_tick && (r_tick_idx == 4'd8);
    assign w_t16  = w_tick && (r_tick_idx == 4'd15);
    // Tick-9 sample is taken live from rx_s alongside the stored tick-7/8 samples.
    assign w_vote = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);

    // Oversampling counters; held clear in IDLE so START always begins at tick 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_tick_idx <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_shift    <= 8'd0;
        end else if (r_state == c_S_IDLE) begin
            r_div_cnt  <= '0;
            r_tick_idx <= 4'd0;
            r_bit_idx  <= 3'd0;
        end else if (w_tick) begin
            r_div_cnt  <= '0;
            r_tick_idx <= r_tick_idx + 4'd1;
            if (r_tick_idx == 4'd6) r_s7 <= r_rx_s;
            if (r_tick_idx == 4'd7) r_s8 <= r_rx_s;
            if (r_state == c_S_DATA && r_tick_idx == 4'd8)
                r_shift <= {w_vote, r_shift[7:1]};
            if (r_state == c_S_DATA && r_tick_idx == 4'd15)
                r_bit_idx <= r_bit_idx + 3'd1;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE:      if (!r_rx_s) w_next = c_S_START;
            c_S_START: begin
                if (w_t9 && w_vote) w_next = c_S_IDLE;
                else if (w_t16)     w_next = c_S_DATA;
            end
            c_S_DATA:      if (w_t16 && r_bit_idx == 3'd7) w_next = c_S_STOP;
            c_S_STOP:      if (w_t9) w_next = w_vote ? c_S_IDLE : c_S_WAIT_IDLE;
            c_S_WAIT_IDLE: if (r_rx_s) w_next = c_S_IDLE;
            default:       w_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != c_S_IDLE);
        w_deliver = (r_state == c_S_STOP) && w_t9 && w_vote;
        w_ferr    = (r_state == c_S_STOP) && w_t9 && !w_vote;
    end

    // The stop decision is registered once, so every output moves one clock later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dlv    <= 1'b0;
            r_ferr_p <= 1'b0;
            r_byte   <= 8'd0;
        end else begin
            r_dlv    <= w_deliver;
            r_ferr_p <= w_ferr;
            if (w_deliver) r_byte <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= 8'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= r_ferr_p;
            overrun   <= 1'b0;
            if (r_dlv) begin
                if (!valid || ready) begin
                    data  <= r_byte;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_link.md
Name: uart_rx_link

Overview:
- Board-to-board serial receiver for the JA0 link pin: synchronises the raw asynchronous rx line and decodes 8N1 UART frames using 16x oversampling with majority voting.
- Presents each received byte on a one-entry valid/ready output register consumed by the game-state link logic.
- Reports framing errors and overruns as single-cycle pulses.
- Instantiated inside top, clocked from the 75 MHz system clock.

Parameters:
- CLK_HZ, 75_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; fixed at 16, other values unsupported.
- DIV, (CLK_HZ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE), clocks per tick; 41 at defaults, giving a 656-clock bit period.

Ports:
- clk  in  1  system clock (75 MHz)
- rst  in  1  synchronous reset, active-high
- rx  in  1  raw asynchronous serial input; idle high
- data  out  8  received byte, LSB first on the line
- valid  out  1  data holds an unconsumed byte
- ready  in  1  consumer accepts data when valid && ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: byte dropped because the holding register was full
- busy  out  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE, both synchroniser flops=1, tick and bit counters cleared.
  - Reset mid-frame abandons the frame and discards the partial byte.
- Synchroniser: two flops, rx -> rx_s; adds 2 clocks of latency. All decoding uses rx_s only.
- Tick generator:
  - Counter cleared on entry to START.
  - Emits a tick every DIV clocks; the first tick comes DIV clocks after entry.
  - Ticks within a bit are numbered 1..16; tick 16 ends the bit.
- Vote: rx_s is captured on ticks 7, 8 and 9; the bit value is the majority of these three samples.
- States:
  - IDLE: busy=0. When rx_s=0, go to START on the next clock.
  - START:
    - At tick 9, if vote=1 (glitch), return to IDLE immediately.
    - At tick 16, go to DATA with bit index 0.
  - DATA:
    - At tick 9, shift the vote into the shift register, LSB first.
    - At tick 16, increment the bit index; after index 7, go to STOP.
  - STOP, decision at tick 9:
    - vote=1: deliver the byte and go to IDLE. Deciding mid-stop allows back-to-back frames.
    - vote=0: pulse frame_err for 1 clock, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE (break / line held low): stay until rx_s=1, then go to IDLE.
- Delivery, registered (outputs change the clock after the tick-9 decision):
  - If valid=0, or valid=1 with ready=1 in the same cycle: data<=byte, valid<=1.
  - If valid=1 and ready=0: pulse overrun for 1 clock; the old data and valid are retained and the new byte is dropped.
- Handshake:
  - valid drops the clock after valid && ready, unless a delivery happens in that same cycle, in which case valid stays 1 with the new data.
  - data is stable while valid=1 && ready=0.
- Latency: the rx falling edge at the pin reaches START entry after 3 clocks. valid rises 153 ticks later plus 1 clock, i.e. 3 + 153*41 + 1 = 6277 clocks at defaults.
- frame_err and overrun are never asserted simultaneously.
- Tolerance: correct reception with line-rate error up to ±3% against BAUD.

Test Plan:
- Single byte: drive 0x55 at 115200 with ready=0 -> valid rises 6277±2 clocks after the start edge, data=0x55, held stable; set ready=1 for 1 clock -> valid=0 on the next clock.
- Glitch rejection: rx low for 200 clocks (<7 ticks), then high -> busy pulses, no valid, no frame_err, back to IDLE; a following 0xC3 is received correctly.
- Framing error: 0xA5 with the stop bit driven low for 2 bit times -> exactly one frame_err pulse, valid stays 0, busy stays high until rx returns high; a following 0x3C is received correctly.
- Overrun: 0x12 then 0x34 back-to-back with ready=0 -> data=0x12, exactly one overrun pulse at the mid-stop of the second frame; a ready pulse then clears valid.
- Back-to-back with ready held 1: 0x00, 0xFF, 0x81 sent consecutively at BAUD*1.03 and again at BAUD*0.97 -> three valid deliveries with correct data; no frame_err or overrun.
- Reset mid-frame: assert rst for 1 clock during data bit 3 of 0x7E -> next clock all outputs 0 and busy=0; the next full frame 0x99 is received correctly.
